// File: rtl/fpu_norm_shifter.sv
// rtl/fpu_norm_shifter.sv - pipelined log-shifter normalizing a mantissa to its leading one
module fpu_norm_shifter #(
    parameter int WIDTH     = 106,
    parameter int WIDTH_LOG = 7,
    parameter int EXP_W     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_mant,
    input  logic [WIDTH_LOG-1:0] in_msb,
    input  logic [EXP_W-1:0]     in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_mant,
    output logic [EXP_W-1:0]     out_exp,
    output logic                 out_zero,
    output logic                 out_uflow,
    output logic                 out_err
);

    localparam logic [WIDTH_LOG-1:0] TOP_IDX  = WIDTH_LOG'(WIDTH - 1);
    localparam logic [WIDTH-1:0]     ONE_BIT  = WIDTH'(1);

    logic [WIDTH_LOG-1:0] v_q, zero_q, uflow_q, err_q;
    logic [WIDTH-1:0]     mant_q  [WIDTH_LOG];
    logic [EXP_W-1:0]     exp_q   [WIDTH_LOG];
    // The last stage has consumed every shift bit, so it carries no shift amount.
    logic [WIDTH_LOG-1:0] shamt_q [WIDTH_LOG-1];
    logic [WIDTH-1:0]     nxt_mant [WIDTH_LOG];

    logic                 stall;
    logic                 in_zero, in_err, in_uflow, msb_set;
    logic [WIDTH-1:0]     msb_sel;
    logic [WIDTH_LOG-1:0] in_shift;
    logic [EXP_W-1:0]     in_exp_adj;

    assign out_valid = v_q[WIDTH_LOG-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    always_comb begin
        msb_sel    = ONE_BIT << in_msb;
        msb_set    = |(in_mant & msb_sel);
        in_zero    = (in_mant == '0);
        in_err     = !in_zero && ((in_msb > TOP_IDX) || !msb_set);
        in_shift   = (in_zero || in_err) ? '0 : (TOP_IDX - in_msb);
        // Zero and error operands carry shift 0, so no borrow can be flagged for them.
        in_uflow   = (in_exp < EXP_W'(in_shift));
        in_exp_adj = in_zero ? '0 : (in_exp - EXP_W'(in_shift));
    end

    always_comb begin
        for (int k = 0; k < WIDTH_LOG; k++) begin : stage_shift
            logic [WIDTH-1:0]     src_m;
            logic [WIDTH_LOG-1:0] src_s;
            if (k == 0) begin
                src_m = in_mant;
                src_s = in_shift;
            end else begin
                src_m = mant_q[k-1];
                src_s = shamt_q[k-1];
            end
            nxt_mant[k] = src_s[WIDTH_LOG-1-k] ? (src_m << (1 << (WIDTH_LOG-1-k))) : src_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            zero_q  <= '0;
            uflow_q <= '0;
            err_q   <= '0;
            for (int k = 0; k < WIDTH_LOG; k++) begin
                mant_q[k] <= '0;
                exp_q[k]  <= '0;
            end
            for (int k = 0; k < WIDTH_LOG-1; k++) begin
                shamt_q[k] <= '0;
            end
        end else if (!stall) begin
            v_q[0]     <= in_valid;
            zero_q[0]  <= in_zero;
            uflow_q[0] <= in_uflow;
            err_q[0]   <= in_err;
            mant_q[0]  <= nxt_mant[0];
            exp_q[0]   <= in_exp_adj;
            shamt_q[0] <= in_shift;
            for (int k = 1; k < WIDTH_LOG; k++) begin
                v_q[k]     <= v_q[k-1];
                zero_q[k]  <= zero_q[k-1];
                uflow_q[k] <= uflow_q[k-1];
                err_q[k]   <= err_q[k-1];
                mant_q[k]  <= nxt_mant[k];
                exp_q[k]   <= exp_q[k-1];
            end
            for (int k = 1; k < WIDTH_LOG-1; k++) begin
                shamt_q[k] <= shamt_q[k-1];
            end
        end
    end

    assign out_mant  = mant_q[WIDTH_LOG-1];
    assign out_exp   = exp_q[WIDTH_LOG-1];
    assign out_zero  = zero_q[WIDTH_LOG-1];
    assign out_uflow = uflow_q[WIDTH_LOG-1];
    assign out_err   = err_q[WIDTH_LOG-1];

endmodule

// File: tb/tb_fpu_norm_shifter.sv
// tb/tb_fpu_norm_shifter.sv - randomized scoreboard bench for fpu_norm_shifter
module tb_fpu_norm_shifter;
    localparam int W  = 106;
    localparam int WL = 7;
    localparam int EW = 12;

    typedef struct packed {
        logic [W-1:0]  mant;
        logic [EW-1:0] exp;
        logic          zero;
        logic          uflow;
        logic          err;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_mant = '0;
    logic [WL-1:0] in_msb = '0;
    logic [EW-1:0] in_exp = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_mant;
    logic [EW-1:0] out_exp;
    logic          out_zero, out_uflow, out_err;

    int   errors = 0;
    int   checks = 0;
    res_t sb[$];
    res_t got;

    always #5 clk = ~clk;

    fpu_norm_shifter #(.WIDTH(W), .WIDTH_LOG(WL), .EXP_W(EW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_msb(in_msb), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp),
        .out_zero(out_zero), .out_uflow(out_uflow), .out_err(out_err)
    );

    function automatic res_t model(input logic [W-1:0] m, input logic [WL-1:0] msb, input logic [EW-1:0] e);
        res_t r = '0;
        int   idx = int'(msb);
        int   s;
        if (m == '0) begin
            r.zero = 1'b1;
        end else if (idx > W-1 || m[idx] == 1'b0) begin
            r.err  = 1'b1;
            r.mant = m;
            r.exp  = e;
        end else begin
            s       = W - 1 - idx;
            r.mant  = m << s;
            r.exp   = EW'((int'(e) - s + (1 << EW)) % (1 << EW));
            r.uflow = (int'(e) < s);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_mant();
        return W'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic gen_op(output logic [W-1:0] m, output logic [WL-1:0] msb, output logic [EW-1:0] e);
        logic [W-1:0] one = W'(1);
        int kind = $urandom_range(0, 9);
        int p    = $urandom_range(0, W-1);
        e = EW'($urandom());
        case (kind)
            0: begin m = '0; msb = WL'($urandom()); end
            1: begin
                msb = WL'(p);
                m = rand_mant() & ~(one << p);
                if (m == '0) m = one << ((p + 1) % W);
            end
            2: begin msb = WL'($urandom_range(W, (1 << WL) - 1)); m = rand_mant() | one; end
            default: begin msb = WL'(p); m = (rand_mant() & ((one << p) - one)) | (one << p); end
        endcase
    endtask

    task automatic drive(input logic v, input logic [W-1:0] m, input logic [WL-1:0] msb,
                         input logic [EW-1:0] e, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_mant   = m;
        in_msb    = msb;
        in_exp    = e;
        out_ready = r;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        got = {out_mant, out_exp, out_zero, out_uflow, out_err};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", got); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0]  one = W'(1);
        logic [W-1:0]  dm[6];
        logic [WL-1:0] dmsb[6];
        logic [EW-1:0] de[6];
        res_t          dexp[6];
        int            idx = 0;
        int            first_out = -1;
        dm[0] = one;                dmsb[0] = 0;   de[0] = 200; dexp[0] = '{one << 105, 95, 0, 0, 0};
        dm[1] = (one << 105) | 3;   dmsb[1] = 105; de[1] = 50;  dexp[1] = '{(one << 105) | 3, 50, 0, 0, 0};
        dm[2] = '0;                 dmsb[2] = 17;  de[2] = 99;  dexp[2] = '{'0, 0, 1, 0, 0};
        dm[3] = one;                dmsb[3] = 0;   de[3] = 10;  dexp[3] = '{one << 105, 4001, 0, 1, 0};
        dm[4] = W'(4);              dmsb[4] = 110; de[4] = 33;  dexp[4] = '{W'(4), 33, 0, 0, 1};
        dm[5] = W'(4);              dmsb[5] = 5;   de[5] = 7;   dexp[5] = '{W'(4), 7, 0, 0, 1};
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (idx < 6) drive(1'b1, dm[idx], dmsb[idx], de[idx], 1'b1);
            else         drive(1'b0, '0, '0, '0, 1'b1);
            if (out_valid && first_out < 0) first_out = cyc;
            if (out_valid) begin
                got = {out_mant, out_exp, out_zero, out_uflow, out_err};
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL directed_out: unexpected result %h", got); end
                else if (got !== sb[0]) begin errors++; $display("FAIL directed_out: got %h expected %h", got, sb[0]); end
                if (out_ready && sb.size() > 0) void'(sb.pop_front());
            end
            if (in_valid && in_ready) begin sb.push_back(dexp[idx]); idx++; end
        end
        checks++;
        if (first_out != 7) begin errors++; $display("FAIL directed_latency: got %0d expected 7", first_out); end
        checks++;
        if (sb.size() != 0 || idx != 6) begin errors++; $display("FAIL directed_drain: pending %0d sent %0d expected 0 and 6", sb.size(), idx); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  m[10];
        logic [WL-1:0] msb[10];
        logic [EW-1:0] e[10];
        int idx = 0;
        int npop = 0;
        logic rdy;
        for (int i = 0; i < 10; i++) gen_op(m[i], msb[i], e[i]);
        for (int cyc = 0; cyc < 40; cyc++) begin
            rdy = !(cyc >= 8 && cyc <= 10);
            if (idx < 10) drive(1'b1, m[idx], msb[idx], e[idx], rdy);
            else          drive(1'b0, '0, '0, '0, rdy);
            if (cyc >= 8 && cyc <= 10) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready cycle %0d: got %b expected 0", cyc, in_ready); end
            end
            if (out_valid) begin
                got = {out_mant, out_exp, out_zero, out_uflow, out_err};
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL b2b_out: unexpected result %h", got); end
                else if (got !== sb[0]) begin errors++; $display("FAIL b2b_out: got %h expected %h", got, sb[0]); end
                if (out_ready && sb.size() > 0) begin void'(sb.pop_front()); npop++; end
            end
            if (in_valid && in_ready) begin sb.push_back(model(m[idx], msb[idx], e[idx])); idx++; end
        end
        checks++;
        if (npop != 10 || sb.size() != 0) begin errors++; $display("FAIL b2b_count: got %0d results expected 10", npop); end
    endtask

    task automatic test_random();
        logic [W-1:0]  m;
        logic [WL-1:0] msb;
        logic [EW-1:0] e;
        logic v, r;
        gen_op(m, msb, e);
        for (int cyc = 0; cyc < 460; cyc++) begin
            v = (cyc < 400) && ($urandom_range(0, 9) < 7);
            r = (cyc >= 400) || ($urandom_range(0, 9) < 7);
            drive(v, m, msb, e, r);
            checks++;
            if (in_ready !== (out_ready || !out_valid)) begin errors++; $display("FAIL random_in_ready: got %b expected %b", in_ready, out_ready || !out_valid); end
            if (out_valid) begin
                got = {out_mant, out_exp, out_zero, out_uflow, out_err};
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL random_out: unexpected result %h", got); end
                else if (got !== sb[0]) begin errors++; $display("FAIL random_out: got %h expected %h", got, sb[0]); end
                if (out_ready && sb.size() > 0) void'(sb.pop_front());
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(m, msb, e));
                gen_op(m, msb, e);
            end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL random_drain: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0]  m;
        logic [WL-1:0] msb;
        logic [EW-1:0] e;
        int stale = 0;
        int npop = 0;
        for (int i = 0; i < 3; i++) begin
            gen_op(m, msb, e);
            drive(1'b1, m, msb, e, 1'b0);
        end
        repeat (8) drive(1'b0, '0, '0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill: got out_valid %b expected 1", out_valid); end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset: got valid %b ready %b expected 0 1", out_valid, in_ready); end
        got = {out_mant, out_exp, out_zero, out_uflow, out_err};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h expected 0", got); end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            drive(1'b0, '0, '0, '0, 1'b1);
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL mid_stale: got %0d stale results expected 0", stale); end
        gen_op(m, msb, e);
        for (int cyc = 0; cyc < 12; cyc++) begin
            drive(cyc == 0, m, msb, e, 1'b1);
            if (out_valid) begin
                got = {out_mant, out_exp, out_zero, out_uflow, out_err};
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL mid_out: unexpected result %h", got); end
                else if (got !== sb[0]) begin errors++; $display("FAIL mid_out: got %h expected %h", got, sb[0]); end
                if (out_ready && sb.size() > 0) begin void'(sb.pop_front()); npop++; end
            end
            if (in_valid && in_ready) sb.push_back(model(m, msb, e));
        end
        checks++;
        if (npop != 1) begin errors++; $display("FAIL mid_first_result: got %0d results expected 1", npop); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
